lab_4_seg_display: RTL and testbench
====================================

// Module: lab_4_seg_display
// PURPOSE
//  Downstream display stage for the 4-bit free-running counter (0..15).
//  Samples the 4-bit count once per refresh frame and converts it to two decimal digits.
//  Time-multiplexes the digits onto a common-anode 4-digit 7-segment display.
//  Only AN0 (ones) and AN1 (tens) are used; AN2/AN3 stay dark.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot; legal range >= 1
//  BLANK_LZ     1       1 = tens digit dark when value is 0; 0 = tens digit shows '0'
// PORTS
//  clk         in   1  system clock; all logic on posedge clk
//  reset       in   1  synchronous, active-high reset
//  count       in   4  unsigned value 0..15 from the counter stage
//  seg         out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
//  an          out  4  anode enables, active-low; an[0] = ones, an[1] = tens
//  dp          out  1  decimal point, active-low; constant 1 (off)
//  frame_tick  out  1  one-cycle pulse at each frame boundary, when a new count is sampled
// BEHAVIOUR
//  Clock/reset
//   - One clock domain. Reset is synchronous and active-high; it dominates all other events.
//  Reset values
//   - div_cnt = 0, state = ONES, count_q = 0, frame_tick = 0
//   - an = 4'b1111, seg = 7'b1111111, dp = 1
//  Prescaler
//   - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
//   - slot_tick = (div_cnt == REFRESH_DIV-1).
//   - With REFRESH_DIV = 1, slot_tick is high every cycle.
//  Slot FSM (2 states)
//   - ONES -> TENS on slot_tick.
//   - TENS -> ONES on slot_tick. This edge is the frame boundary.
//  Frame boundary (slot_tick && state==TENS)
//   - count_q <= count at that edge.
//   - frame_tick <= 1 for exactly the following cycle; otherwise frame_tick = 0.
//   - count changes at any other time have no effect on the display (no tearing).
//  BCD conversion (from count_q)
//   - tens = (count_q >= 10)
//   - ones = tens ? count_q - 10 : count_q
//   - Values 0..15 only; no other codes are possible.
//  Output registers (1-cycle latency from state/count_q)
//   - ONES: an = 1110, seg = decode(ones)
//   - TENS: an = 1101, seg = decode(tens)
//   - TENS with tens==0 and BLANK_LZ==1: an = 1111, seg = 1111111
//  Segment decode ({g..a}, active-low)
//   - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
//   - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
//  Boundary conditions
//   - Reset mid-slot: outputs go to their reset values at the next edge.
//     The first post-reset cycle then drives ONES with count_q = 0 (an = 1110, seg = 1000000).
//   - count 15 -> 0 wrap is handled by the normal frame sampling path; no special case.
//   - Never more than one anode low at a time.
// TESTING (REFRESH_DIV=4 unless stated)
//  1. Reset held for 3 cycles -> an = 1111, seg = 1111111, dp = 1, frame_tick = 0.
//     First cycle after release -> an = 1110, seg = 1000000.
//  2. count = 7 held for 2 frames -> after the first frame_tick:
//     ONES slot shows an = 1110, seg = 1111000; TENS slot shows an = 1111 (blanked).
//  3. count = 13 held -> slots alternate every 4 cycles:
//     an = 1110 / seg = 0110000, then an = 1101 / seg = 1111001; frame_tick pulses every 8 cycles.
//  4. count = 12, then changed to 15 two cycles into the ONES slot -> display holds "12"
//     until the next frame_tick, then shows "15" (5 = 0010010, 1 = 1111001).
//  5. BLANK_LZ = 0, count = 5 -> TENS slot drives an = 1101, seg = 1000000.
//  6. Reset asserted mid-TENS slot -> next cycle all dark; after release, ONES slot restarts
//     with div_cnt = 0. Also run REFRESH_DIV = 1: digits swap every cycle.

Source files
------------

// File: rtl/lab_4_seg_display.sv
// Two-digit multiplexed 7-segment driver for a 0..15 count; the count is re-sampled once per
// refresh frame so the two digits always belong to the same value.
module lab_4_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick,
    output logic       dbg_state_o
);
    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {ONES = 1'b0, TENS = 1'b1} slot_e;

    slot_e         state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    count_q, count_d;
    logic          frame_tick_q, frame_tick_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          slot_tick;
    logic          frame_edge;
    logic          tens;
    logic [3:0]    ones;

    function automatic logic [6:0] decode(input logic [3:0] digit);
        case (digit)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign slot_tick  = (div_q == DW'(REFRESH_DIV - 1));
    assign frame_edge = slot_tick && (state_q == TENS);
    assign div_d      = slot_tick ? '0 : div_q + DW'(1);

    // Frame sampling: count is only captured when the TENS slot ends.
    assign count_d      = frame_edge ? count : count_q;
    assign frame_tick_d = frame_edge;

    assign tens = (count_q >= 4'd10);
    assign ones = tens ? count_q - 4'd10 : count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ONES;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (slot_tick) begin
            case (state_q)
                ONES:    state_d = TENS;
                TENS:    state_d = ONES;
                default: state_d = ONES;
            endcase
        end
    end

    always_comb begin
        an_d  = 4'b1110;
        seg_d = decode(ones);
        if (state_q == TENS) begin
            if (!tens && BLANK_LZ) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
            end else begin
                an_d  = 4'b1101;
                seg_d = decode({3'b000, tens});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            count_q      <= 4'd0;
            frame_tick_q <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
        end else begin
            div_q        <= div_d;
            count_q      <= count_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = 1'b1;
    assign frame_tick  = frame_tick_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_lab_4_seg_display.sv
// Bench for lab_4_seg_display: three instances (REFRESH_DIV 4/4/1, BLANK_LZ 1/0/1) checked every
// cycle against a frame/slot arithmetic model, plus literal checks of the documented scenarios.
module tb_lab_4_seg_display;
  localparam int NI = 3;
  localparam int NT [NI] = '{4, 4, 1};
  localparam bit BLZ [NI] = '{1'b1, 1'b0, 1'b1};

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic [6:0] seg_w [NI];
  logic [3:0] an_w [NI];
  logic       dp_w [NI];
  logic       ft_w [NI];
  logic       st_w [NI];

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int         e_m [NI];
  int         cq_m [NI];
  logic [3:0] exp_an [NI];
  logic [6:0] exp_seg [NI];
  logic       exp_ft [NI];

  lab_4_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (
    .clk(clk), .reset(reset), .count(count), .seg(seg_w[0]), .an(an_w[0]),
    .dp(dp_w[0]), .frame_tick(ft_w[0]), .dbg_state_o(st_w[0]));
  lab_4_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut1 (
    .clk(clk), .reset(reset), .count(count), .seg(seg_w[1]), .an(an_w[1]),
    .dp(dp_w[1]), .frame_tick(ft_w[1]), .dbg_state_o(st_w[1]));
  lab_4_seg_display #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) dut2 (
    .clk(clk), .reset(reset), .count(count), .seg(seg_w[2]), .an(an_w[2]),
    .dp(dp_w[2]), .frame_tick(ft_w[2]), .dbg_state_o(st_w[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: e = clock edges since reset release. Output after edge e shows the slot that was
  // active during edge e (slot index (e-1)/N), using the value sampled at the last frame
  // boundary; boundaries fall on edges that are multiples of 2N.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        e_m[i] = 0;
        cq_m[i] = 0;
        exp_an[i] = 4'b1111;
        exp_seg[i] = 7'b1111111;
        exp_ft[i] = 1'b0;
      end else begin
        e_m[i] = e_m[i] + 1;
        if ((((e_m[i] - 1) / NT[i]) % 2) == 0) begin
          exp_an[i] = 4'b1110;
          exp_seg[i] = seg_tab[cq_m[i] % 10];
        end else if ((cq_m[i] / 10) == 0 && BLZ[i]) begin
          exp_an[i] = 4'b1111;
          exp_seg[i] = 7'b1111111;
        end else begin
          exp_an[i] = 4'b1101;
          exp_seg[i] = seg_tab[cq_m[i] / 10];
        end
        exp_ft[i] = ((e_m[i] % (2 * NT[i])) == 0);
        if (exp_ft[i]) cq_m[i] = int'(count);
      end
    end
  end

  // scoreboard compare, every cycle once reset has been seen
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("an[%0d]", i), 32'(an_w[i]), 32'(exp_an[i]));
        chk($sformatf("seg[%0d]", i), 32'(seg_w[i]), 32'(exp_seg[i]));
        chk($sformatf("frame_tick[%0d]", i), 32'(ft_w[i]), 32'(exp_ft[i]));
        chk($sformatf("dp[%0d]", i), 32'(dp_w[i]), 32'd1);
        chk($sformatf("one_anode[%0d]", i), 32'($countones(~an_w[i]) <= 1), 32'd1);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    count = 4'd0;
    cycles(3);
    chk_en = 1;
    chk("rst_an", 32'(an_w[0]), 32'hF);
    chk("rst_seg", 32'(seg_w[0]), 32'h7F);
    chk("rst_dp", 32'(dp_w[0]), 32'd1);
    chk("rst_ft", 32'(ft_w[0]), 32'd0);

    reset = 1'b0;
    count = 4'd7;
    cycles(1);
    chk("post_rst_an", 32'(an_w[0]), 32'hE);
    chk("post_rst_seg", 32'(seg_w[0]), 32'h40);

    // wait (bounded) for the first frame boundary, then check the "7" frame
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (ft_w[0]) seen = 1;
      else cycles(1);
    end
    chk("ft_seen", 32'(seen), 32'd1);
    cycles(1);
    chk("seven_ones_an", 32'(an_w[0]), 32'hE);
    chk("seven_ones_seg", 32'(seg_w[0]), 32'h78);
    cycles(4);
    chk("seven_tens_blank_an", 32'(an_w[0]), 32'hF);
    chk("seven_tens_blank_seg", 32'(seg_w[0]), 32'h7F);
    chk("seven_tens_nolz_an", 32'(an_w[1]), 32'hD);
    chk("seven_tens_nolz_seg", 32'(seg_w[1]), 32'h40);

    // 13 held: ones slot 3, tens slot 1 once sampled
    count = 4'd13;
    cycles(4);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (ft_w[0]) seen = 1;
      else cycles(1);
    end
    chk("ft_seen_13", 32'(seen), 32'd1);
    cycles(1);
    chk("thirteen_ones_seg", 32'(seg_w[0]), 32'h30);
    cycles(4);
    chk("thirteen_tens_an", 32'(an_w[0]), 32'hD);
    chk("thirteen_tens_seg", 32'(seg_w[0]), 32'h79);

    // randomized traffic with occasional mid-slot resets
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 5) == 0) count = 4'($urandom_range(0, 15));
      cycles(1);
    end
    reset = 1'b0;
    cycles(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
